// File: rtl/booth_radix4_mult_if.sv
// -----------------------------------------------------------------------------
// booth_radix4_mult_if
//
// Request/response bundle for the radix-4 Booth multiplier.
//
//   start     request; accepted only while ready=1
//   m_signed  1: M is two's complement, 0: M is unsigned
//   q_signed  1: Q is two's complement, 0: Q is unsigned
//   M, Q      multiplicand / multiplier, WIDTH bits each
//   ready     unit idle, a start is accepted on the next edge
//   busy      multiplication in progress
//   done      one-cycle pulse on the cycle result is updated
//   result    2*WIDTH-bit product, held until the next done
//
// The master modport is the requester; the slave modport is the multiplier.
// -----------------------------------------------------------------------------
interface booth_radix4_mult_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               m_signed;
  logic               q_signed;
  logic [WIDTH-1:0]   M;
  logic [WIDTH-1:0]   Q;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, m_signed, q_signed, M, Q,
    input  ready, busy, done, result
  );

  modport slave (
    input  start, m_signed, q_signed, M, Q,
    output ready, busy, done, result
  );
endinterface

// File: rtl/booth_radix4_mult.sv
// -----------------------------------------------------------------------------
// booth_radix4_mult
//
// Sequential radix-4 (modified) Booth multiplier with per-operand signedness.
// One operation in flight; each operation takes ITER = WIDTH/2+1 steps.
//
// Ports:
//   clk    rising-edge system clock
//   n_rst  asynchronous active-low reset
//   bus    booth_radix4_mult_if.slave (start, m_signed, q_signed, M, Q in;
//          ready, busy, done, result out)
//
// Operation:
//   IDLE  ready=1; start loads the operands (extended to E=WIDTH+2 bits by
//         their own mode bit) and enters CALC.
//   CALC  busy=1; one Booth step per edge. The edge completing step ITER
//         writes result and enters DONE.
//   DONE  done=1 for one cycle, then IDLE.
//
// Extending both operands by two bits makes every mode combination a plain
// signed E x E multiply, so unsigned all-ones and the most-negative value need
// no special handling. E is even, so ITER = E/2 Booth digits cover it exactly.
// -----------------------------------------------------------------------------
module booth_radix4_mult #(
  parameter  int WIDTH = 32,
  localparam int ITER  = WIDTH / 2 + 1
) (
  input  logic               clk,
  input  logic               n_rst,
  booth_radix4_mult_if.slave bus
);

  // Extended operand width and accumulator width. The accumulator carries two
  // guard bits above E so that acc +/- 2M never wraps.
  localparam int E  = WIDTH + 2;
  localparam int AW = E + 2;
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t              state;
  logic signed [AW-1:0] acc;
  logic [E-1:0]         mcand;     // extended multiplicand, captured at load
  logic [E-1:0]         mplier;    // shifting multiplier / low product bits
  logic                 q_m1;      // implicit Q[-1]
  logic [CW-1:0]        step_cnt;

  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   result_q;

  // ---------------------------------------------------------------------------
  // One Booth step: recode the triplet, add, then arithmetic shift
  // {acc, mplier, q_m1} right by two.
  // ---------------------------------------------------------------------------
  logic [2:0]           triplet;
  logic signed [AW-1:0] m_wide;
  logic signed [AW-1:0] m_dbl;
  logic signed [AW-1:0] addend;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_next;
  logic [E-1:0]         mplier_next;
  logic                 q_m1_next;

  // NOTE: every always_comb output gets a value before any branch, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    triplet = {mplier[1:0], q_m1};
    m_wide  = {{2{mcand[E-1]}}, mcand};
    m_dbl   = {m_wide[AW-2:0], 1'b0};
    addend  = '0;

    unique case (triplet)
      3'b001, 3'b010: addend = m_wide;
      3'b011:         addend = m_dbl;
      3'b100:         addend = -m_dbl;
      3'b101, 3'b110: addend = -m_wide;
      default:        addend = '0;     // 000 / 111
    endcase

    sum = acc + addend;

    // The two bits leaving the accumulator enter the top of the multiplier;
    // the multiplier's bit 1 becomes the next Q[-1].
    acc_next    = {{2{sum[AW-1]}}, sum[AW-1:2]};
    mplier_next = {sum[1:0], mplier[E-1:2]};
    q_m1_next   = mplier[1];
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: the datapath registers are reset along with the control state
      // so an aborted operation leaves nothing behind in them.
      state    <= IDLE;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      q_m1     <= 1'b0;
      step_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            mcand    <= bus.m_signed ? {{2{bus.M[WIDTH-1]}}, bus.M}
                                     : {2'b00, bus.M};
            mplier   <= bus.q_signed ? {{2{bus.Q[WIDTH-1]}}, bus.Q}
                                     : {2'b00, bus.Q};
            acc      <= '0;
            q_m1     <= 1'b0;
            step_cnt <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state    <= CALC;
          end
        end

        CALC: begin
          acc      <= acc_next;
          mplier   <= mplier_next;
          q_m1     <= q_m1_next;
          step_cnt <= step_cnt + CW'(1);
          if (step_cnt == CW'(ITER - 1)) begin
            // After the last step the multiplier register holds the low E
            // product bits and the accumulator holds the rest.
            result_q <= {acc_next[2*WIDTH-E-1:0], mplier_next};
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_mult
//
// Drives a WIDTH=32 and a WIDTH=8 instance of booth_radix4_mult and compares
// every product against an arithmetic reference (operands interpreted as
// signed or unsigned integers and multiplied directly). Inputs change and
// outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_booth_radix4_mult;

  localparam int ITER32 = 32 / 2 + 1;
  localparam int ITER8  = 8 / 2 + 1;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  booth_radix4_mult_if #(.WIDTH(32)) bus32 ();
  booth_radix4_mult_if #(.WIDTH(8))  bus8 ();

  booth_radix4_mult #(.WIDTH(32)) dut32 (.clk(clk), .n_rst(n_rst), .bus(bus32));
  booth_radix4_mult #(.WIDTH(8))  dut8  (.clk(clk), .n_rst(n_rst), .bus(bus8));

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------------------
  // Reference: value of a w-bit operand as an integer, exact product, low 2w
  // bits.
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] m,
                                          input logic [31:0] q,
                                          input logic ms, input logic qs);
    logic signed [65:0] a, b, p;
    logic [63:0] mask;
    a = 66'(m);
    b = 66'(q);
    if (ms && m[w-1]) a = a - (66'sd1 <<< w);
    if (qs && q[w-1]) b = b - (66'sd1 <<< w);
    p    = a * b;
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    return p[63:0] & mask;
  endfunction

  function automatic logic [31:0] pick(input int w);
    logic [31:0] v;
    logic [31:0] msb;
    msb = 32'h1 << (w - 1);
    case ($urandom_range(0, 6))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = msb;
      3:       v = msb - 32'h1;
      4:       v = 32'h1;
      default: v = $urandom();
    endcase
    return (w == 32) ? v : (v & ((32'h1 << w) - 32'h1));
  endfunction

  // Accessors so one driver task serves both instances.
  function automatic logic get_ready(input bit is8);
    return is8 ? bus8.ready : bus32.ready;
  endfunction
  function automatic logic get_busy(input bit is8);
    return is8 ? bus8.busy : bus32.busy;
  endfunction
  function automatic logic get_done(input bit is8);
    return is8 ? bus8.done : bus32.done;
  endfunction
  function automatic logic [63:0] get_result(input bit is8);
    return is8 ? {48'h0, bus8.result} : bus32.result;
  endfunction

  task automatic drive(input bit is8, input logic [31:0] m, input logic [31:0] q,
                       input logic ms, input logic qs, input logic st);
    if (is8) begin
      bus8.M = m[7:0]; bus8.Q = q[7:0];
      bus8.m_signed = ms; bus8.q_signed = qs; bus8.start = st;
    end else begin
      bus32.M = m; bus32.Q = q;
      bus32.m_signed = ms; bus32.q_signed = qs; bus32.start = st;
    end
  endtask

  task automatic set_start(input bit is8, input logic st);
    if (is8) bus8.start = st;
    else     bus32.start = st;
  endtask

  // Runs one operation from a falling edge. done_edge counts edges from the
  // start-sampling edge (edge 0) to the first edge at which done is high.
  // Returns on the falling edge where done is first seen.
  task automatic do_op(input bit is8, input logic [31:0] m, input logic [31:0] q,
                       input logic ms, input logic qs,
                       output logic [63:0] res, output int done_edge,
                       output int busy_cycles, output bit ready_low,
                       output bit timed_out);
    int e;
    res = '0; done_edge = -1; busy_cycles = 0; ready_low = 1'b1; timed_out = 1'b0;
    e = 0;
    while (get_ready(is8) !== 1'b1 && e < 40) begin
      @(negedge clk);
      e++;
    end
    if (get_ready(is8) !== 1'b1) begin
      timed_out = 1'b1;
      return;
    end
    drive(is8, m, q, ms, qs, 1'b1);
    @(negedge clk);
    set_start(is8, 1'b0);
    for (int k = 0; k < 100; k++) begin
      if (get_busy(is8) === 1'b1) busy_cycles++;
      if (get_ready(is8) !== 1'b0) ready_low = 1'b0;
      if (get_done(is8) === 1'b1) begin
        done_edge = k + 1;
        res = get_result(is8);
        return;
      end
      @(negedge clk);
    end
    timed_out = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      bit is8;
      is8 = (d == 1);
      n_checks++;
      if (get_ready(is8) !== 1'b1) $display("FAIL reset_ready w8=%0d: got %b expected 1", is8, get_ready(is8));
      else n_pass++;
      n_checks++;
      if (get_busy(is8) !== 1'b0) $display("FAIL reset_busy w8=%0d: got %b expected 0", is8, get_busy(is8));
      else n_pass++;
      n_checks++;
      if (get_done(is8) !== 1'b0) $display("FAIL reset_done w8=%0d: got %b expected 0", is8, get_done(is8));
      else n_pass++;
      n_checks++;
      if (get_result(is8) !== 64'h0) $display("FAIL reset_result w8=%0d: got %h expected 0", is8, get_result(is8));
      else n_pass++;
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] m;
    logic [31:0] q;
    logic        ms;
    logic        qs;
    logic [63:0] exp;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [6];
    logic [63:0] res;
    int de, bc;
    bit rl, to;
    vecs[0] = '{32'd8,         32'd20,        1'b1, 1'b1, 64'h0000_0000_0000_00A0};
    vecs[1] = '{32'hFFFF_FFF8, 32'h10,        1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[2] = '{32'hFFFF_FFD5, 32'd3,         1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF7F};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001};
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, vecs[i].m, vecs[i].q, vecs[i].ms, vecs[i].qs, res, de, bc, rl, to);
      n_checks++;
      if (to || res !== vecs[i].exp)
        $display("FAIL directed32[%0d] result: got %h expected %h (timeout=%0d)", i, res, vecs[i].exp, to);
      else n_pass++;
      n_checks++;
      if (!rl) $display("FAIL directed32[%0d] ready_during_op: got high expected low", i);
      else n_pass++;
      if (i == 0) begin
        n_checks++;
        if (de !== ITER32 + 1) $display("FAIL latency32: done at edge %0d expected %0d", de, ITER32 + 1);
        else n_pass++;
        n_checks++;
        if (bc !== ITER32) $display("FAIL busy_cycles32: got %0d expected %0d", bc, ITER32);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus32.ready !== 1'b1 || bus32.done !== 1'b0)
          $display("FAIL after_done32: ready=%b done=%b expected ready=1 done=0", bus32.ready, bus32.done);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus32.result !== vecs[i].exp) $display("FAIL result_hold32: got %h expected %h", bus32.result, vecs[i].exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random_modes();
    logic [63:0] res, exp;
    logic [31:0] m, q;
    logic ms, qs;
    int de, bc;
    bit rl, to;
    for (int i = 0; i < 60; i++) begin
      m = pick(32); q = pick(32);
      ms = 1'($urandom_range(0, 1)); qs = 1'($urandom_range(0, 1));
      exp = ref_mul(32, m, q, ms, qs);
      do_op(1'b0, m, q, ms, qs, res, de, bc, rl, to);
      n_checks++;
      if (to || res !== exp || de !== ITER32 + 1)
        $display("FAIL random32 %h*%h ms=%b qs=%b: got %h at edge %0d expected %h at edge %0d",
                 m, q, ms, qs, res, de, exp, ITER32 + 1);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] ma, qa, mb, qb;
    logic ms, qs;
    logic [63:0] exp, res;
    bit rl, seen;
    ma = $urandom(); qa = $urandom(); mb = ~ma; qb = qa ^ 32'h5A5A_0F0F;
    ms = 1'b1; qs = 1'b0;
    exp = ref_mul(32, ma, qa, ms, qs);
    @(negedge clk);
    drive(1'b0, ma, qa, ms, qs, 1'b1);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    repeat (4) @(negedge clk);
    // A second request with different operands and modes lands mid-operation.
    drive(1'b0, mb, qb, ~ms, ~qs, 1'b1);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    rl = 1'b1; seen = 1'b0; res = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus32.ready !== 1'b0) rl = 1'b0;
      if (bus32.done === 1'b1) begin
        seen = 1'b1;
        res = bus32.result;
      end else @(negedge clk);
    end
    // Request during DONE: must not be queued.
    set_start(1'b0, 1'b1);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    n_checks++;
    if (!seen || res !== exp) $display("FAIL start_ignored result: got %h expected %h (done_seen=%0d)", res, exp, seen);
    else n_pass++;
    n_checks++;
    if (!rl) $display("FAIL start_ignored ready: got high expected low during CALC/DONE");
    else n_pass++;
    n_checks++;
    if (bus32.ready !== 1'b1) $display("FAIL start_ignored ready_return: got %b expected 1", bus32.ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus32.busy !== 1'b0 || bus32.ready !== 1'b1)
      $display("FAIL start_in_done_queued: busy=%b ready=%b expected busy=0 ready=1", bus32.busy, bus32.ready);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] om [3];
    logic [31:0] oq [3];
    logic        oms[3];
    logic        oqs[3];
    logic [63:0] got[3];
    int at[3];
    int k;
    for (int i = 0; i < 3; i++) begin
      om[i] = $urandom() | 32'h1; oq[i] = $urandom() | 32'h1;
      oms[i] = 1'($urandom_range(0, 1)); oqs[i] = 1'($urandom_range(0, 1));
      got[i] = '0; at[i] = 0;
    end
    k = 0;
    drive(1'b0, om[0], oq[0], oms[0], oqs[0], 1'b1);
    for (int cyc = 0; cyc < 200 && k < 3; cyc++) begin
      @(negedge clk);
      if (bus32.done === 1'b1) begin
        got[k] = bus32.result;
        at[k] = cyc;
        k++;
        if (k < 3) drive(1'b0, om[k], oq[k], oms[k], oqs[k], 1'b1);
        else set_start(1'b0, 1'b0);
      end
    end
    set_start(1'b0, 1'b0);
    n_checks++;
    if (k != 3) $display("FAIL b2b_pulses: got %0d done pulses expected 3", k);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== ref_mul(32, om[i], oq[i], oms[i], oqs[i]))
        $display("FAIL b2b_result[%0d]: got %h expected %h", i, got[i], ref_mul(32, om[i], oq[i], oms[i], oqs[i]));
      else n_pass++;
    end
    for (int i = 1; i < 3; i++) begin
      n_checks++;
      if (at[i] - at[i-1] != ITER32 + 2)
        $display("FAIL b2b_spacing[%0d]: got %0d cycles expected %0d", i, at[i] - at[i-1], ITER32 + 2);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] res;
    int de, bc;
    bit rl, to, seen;
    drive(1'b0, 32'h1234_5678, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    set_start(1'b0, 1'b0);
    repeat (5) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    n_checks++;
    if (bus32.ready !== 1'b1) $display("FAIL midreset_ready: got %b expected 1", bus32.ready);
    else n_pass++;
    n_checks++;
    if (bus32.busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", bus32.busy);
    else n_pass++;
    n_checks++;
    if (bus32.result !== 64'h0) $display("FAIL midreset_result: got %h expected 0", bus32.result);
    else n_pass++;
    @(negedge clk);
    n_rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done === 1'b1 || bus32.busy === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) $display("FAIL midreset_resumed: got done/busy activity expected none");
    else n_pass++;
    do_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, res, de, bc, rl, to);
    n_checks++;
    if (to || res !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL post_reset_op: got %h expected %h (timeout=%0d)", res, 64'hFFFF_FFFF_FFFF_FFEB, to);
    else n_pass++;
  endtask

  task automatic test_width8();
    logic [7:0]  corners [8];
    logic [63:0] res, exp;
    logic [31:0] m, q;
    logic ms, qs;
    int de, bc, bad;
    bit rl, to;
    corners = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    do_op(1'b1, 32'h80, 32'h7F, 1'b1, 1'b1, res, de, bc, rl, to);
    n_checks++;
    if (to || res !== 64'hC080) $display("FAIL w8_signed_min: got %h expected c080", res);
    else n_pass++;
    n_checks++;
    if (de !== ITER8 + 1) $display("FAIL latency8: done at edge %0d expected %0d", de, ITER8 + 1);
    else n_pass++;

    do_op(1'b1, 32'hFF, 32'hFF, 1'b0, 1'b0, res, de, bc, rl, to);
    n_checks++;
    if (to || res !== 64'hFE01) $display("FAIL w8_unsigned_max: got %h expected fe01", res);
    else n_pass++;

    // Corner operand grid in all four modes.
    bad = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int md = 0; md < 4; md++) begin
          m = {24'h0, corners[i]}; q = {24'h0, corners[j]};
          ms = md[1]; qs = md[0];
          exp = ref_mul(8, m, q, ms, qs);
          do_op(1'b1, m, q, ms, qs, res, de, bc, rl, to);
          n_checks++;
          if (to || res !== exp) begin
            bad++;
            if (bad <= 10)
              $display("FAIL w8_corner %h*%h ms=%b qs=%b: got %h expected %h", m[7:0], q[7:0], ms, qs, res, exp);
          end else n_pass++;
        end

    for (int i = 0; i < 150; i++) begin
      m = pick(8); q = pick(8);
      ms = 1'($urandom_range(0, 1)); qs = 1'($urandom_range(0, 1));
      exp = ref_mul(8, m, q, ms, qs);
      do_op(1'b1, m, q, ms, qs, res, de, bc, rl, to);
      n_checks++;
      if (to || res !== exp || de !== ITER8 + 1)
        $display("FAIL w8_random %h*%h ms=%b qs=%b: got %h at edge %0d expected %h at edge %0d",
                 m[7:0], q[7:0], ms, qs, res, de, exp, ITER8 + 1);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_modes();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
